aes_key_expand_seq: RTL and testbench

Iterative AES-128 key-schedule engine that sits directly upstream of the AES_Encrypt / AES_Decrypt datapaths. It accepts a 128-bit cipher key, computes one round key per clock, and stores all 11 round keys in an internal register file. A random-access read port serves round keys in forward order for encryption and reverse order for decryption, so the cipher cores no longer expand the key combinationally.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_key_expand_seq.sv | 180 ++++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key-schedule engine and the cipher cores.
//   NR_AES128    : number of rounds for AES-128
//   aes_word_t   : 32-bit column word
//   aes_block_t  : 128-bit state / round key, w0 in bits [127:96]
//   round_idx_t  : 4-bit round-key index
//   kx_state_t   : key-expansion FSM states
//   RCON         : round constants, meaningful at indices 1..10
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;
    typedef logic [3:0]   round_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } kx_state_t;

    // Padded to 16 entries so any 4-bit round index reads a defined value;
    // index 0 and 11..15 never contribute to a real round key.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] aes_rcon(input round_idx_t r);
        return RCON[r];
    endfunction

    // RotWord: cyclic left rotation by one byte.
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box (byte substitution).
//   value : input byte
//   subst : substituted byte
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign subst = SBOX[value];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one round key per clock into an
// 11-entry register file, with a random-access read port for the cipher
// cores (forward order for encrypt, reverse for decrypt).
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle request; accepted in IDLE or DONE, ignored while busy
//   key_in     : cipher key, w0 in [127:96]; sampled on the accepted start edge
//   busy       : expansion in progress
//   keys_valid : all NR+1 round keys stored and stable
//   rd_addr    : round-key index; indices above NR read as zero
//   rd_data    : round key[rd_addr]; combinational (RD_REG=0) or one-cycle registered (RD_REG=1)
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NR     = NR_AES128,
    parameter bit RD_REG = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data
);

    localparam round_idx_t LAST_IDX = round_idx_t'(NR);

    kx_state_t  state_reg;
    round_idx_t round_reg;
    logic       busy_reg;
    logic       keys_valid_reg;
    // Copy of the most recently written round key, so the round function
    // never needs a read mux on the register file.
    aes_block_t last_key_reg;
    aes_block_t rk_reg [NR+1];

    // ------------------------------------------------------------------
    // Round function: rk[round] from rk[round-1]
    // ------------------------------------------------------------------
    aes_word_t w0_prev, w1_prev, w2_prev, w3_prev;
    aes_word_t rot_w3, sub_w3, t_word;
    aes_word_t w0_next, w1_next, w2_next, w3_next;
    aes_block_t next_key;

    assign {w0_prev, w1_prev, w2_prev, w3_prev} = last_key_reg;
    assign rot_w3 = rot_word(w3_prev);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .value (rot_w3[8*gi +: 8]),
                .subst (sub_w3[8*gi +: 8])
            );
        end
    endgenerate

    assign t_word   = sub_w3 ^ {aes_rcon(round_reg), 24'h000000};
    assign w0_next  = w0_prev ^ t_word;
    assign w1_next  = w1_prev ^ w0_next;
    assign w2_next  = w2_prev ^ w1_next;
    assign w3_next  = w3_prev ^ w2_next;
    assign next_key = {w0_next, w1_next, w2_next, w3_next};

    // ------------------------------------------------------------------
    // Register-file write port: key_in to entry 0 on an accepted start,
    // otherwise the freshly computed round key during expansion.
    // ------------------------------------------------------------------
    logic       wr_en;
    round_idx_t wr_idx;
    aes_block_t wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = key_in;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                wr_en = start;
            end
            ST_EXPAND: begin
                wr_en   = 1'b1;
                wr_idx  = round_reg;
                wr_data = next_key;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                rk_reg[i] <= '0;
            end
        end else if (wr_en) begin
            rk_reg[wr_idx] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            round_reg      <= '0;
            busy_reg       <= 1'b0;
            keys_valid_reg <= 1'b0;
            last_key_reg   <= '0;
        end else begin
            if (wr_en) begin
                last_key_reg <= wr_data;
            end
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    // A start in DONE drops keys_valid on the same edge that
                    // overwrites rk[0]; older entries are replaced round by round.
                    if (start) begin
                        state_reg      <= ST_EXPAND;
                        round_reg      <= round_idx_t'(1);
                        busy_reg       <= 1'b1;
                        keys_valid_reg <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    if (round_reg == LAST_IDX) begin
                        state_reg      <= ST_DONE;
                        round_reg      <= '0;
                        busy_reg       <= 1'b0;
                        keys_valid_reg <= 1'b1;
                    end else begin
                        round_reg <= round_idx_t'(round_reg + 4'd1);
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    round_reg      <= '0;
                    busy_reg       <= 1'b0;
                    keys_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign keys_valid = keys_valid_reg;

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    aes_block_t rd_sel;

    always_comb begin
        rd_sel = '0;
        if (rd_addr <= LAST_IDX) begin
            rd_sel = rk_reg[rd_addr];
        end
    end

    generate
        if (RD_REG) begin : g_rd_reg
            aes_block_t rd_data_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_reg <= '0;
                end else begin
                    rd_data_reg <= rd_sel;
                end
            end
            assign rd_data = rd_data_reg;
        end else begin : g_rd_comb
            assign rd_data = rd_sel;
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Testbench for aes_key_expand_seq. Two instances share all inputs: one with a
// combinational read port, one with a registered read port. Reads are issued
// as transactions into two expectation queues; a monitor on the falling edge
// pops and compares each instance's rd_data when its data is due.
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   rd_addr = '0;

    logic         busy, keys_valid, busy_r, keys_valid_r;
    logic [127:0] rd_data, rd_data_r;

    aes_key_expand_seq #(.NR(10), .RD_REG(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    aes_key_expand_seq #(.NR(10), .RD_REG(1'b1)) dut_r (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy_r),
        .keys_valid (keys_valid_r),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data_r)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: FIPS-197 key expansion over a 44-word array, with the
    // S-box derived from the GF(2^8) inverse and affine map, and RCON by
    // repeated doubling in GF(2^8).
    // ------------------------------------------------------------------
    logic [7:0]   sb_tab [256];
    logic [127:0] model_keys [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sb_tab[temp[31:24]], sb_tab[temp[23:16]], sb_tab[temp[15:8]], sb_tab[temp[7:0]]};
                temp = temp ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ------------------------------------------------------------------
    // Read transactions and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]   addr;
        logic [127:0] exp;
        int           cyc;
    } rd_txn_t;

    rd_txn_t cq[$];
    rd_txn_t rq[$];

    task automatic issue_read(input logic [3:0] a, input logic [127:0] exp);
        rd_txn_t t;
        @(posedge clk);
        #1;
        rd_addr = a;
        t.addr = a;
        t.exp  = exp;
        t.cyc  = cyc;
        cq.push_back(t);
        rq.push_back(t);
    endtask

    task automatic issue_model_read(input logic [3:0] a);
        logic [127:0] e;
        e = '0;
        if (a <= 4'd10) e = model_keys[a];
        issue_read(a, e);
    endtask

    always @(negedge clk) begin
        rd_txn_t t;
        if (cq.size() > 0) begin
            t = cq.pop_front();
            check($sformatf("rd_comb[%0d]", t.addr), rd_data, t.exp);
        end
        if (rq.size() > 0 && cyc >= rq[0].cyc + 1) begin
            t = rq.pop_front();
            check($sformatf("rd_reg[%0d]", t.addr), rd_data_r, t.exp);
        end
    end

    task automatic drain();
        for (int i = 0; i < 8 && (cq.size() > 0 || rq.size() > 0); i++) @(negedge clk);
        #1;
        check("drain_pending", 128'(cq.size() + rq.size()), 128'd0);
    endtask

    // Start an expansion and wait for keys_valid. If inject_at > 0, a second
    // start with key2 is presented before that expansion edge and must be ignored.
    task automatic run_expand(input logic [127:0] key, input int inject_at, input logic [127:0] key2);
        int lat;
        build_model(key);
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = key;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        check("busy_after_start", 128'(busy), 128'd1);
        check("kv_after_start", 128'({keys_valid, keys_valid_r}), 128'd0);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            if (inject_at > 0 && n == inject_at) begin
                start  = 1'b1;
                key_in = key2;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat = n;
            if (keys_valid) break;
            if (n == inject_at || n == 9) check($sformatf("busy_cycle%0d", n), 128'(busy), 128'd1);
        end
        check("kv_latency", 128'(lat), 128'd10);
        check("busy_done", 128'({busy, busy_r}), 128'd0);
        check("kv_r_done", 128'(keys_valid_r), 128'd1);
    endtask

    localparam logic [127:0] KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KA_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KA_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KB_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] k1, k2;
        init_sbox();

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 128'({busy, busy_r}), 128'd0);
        check("reset_kv", 128'({keys_valid, keys_valid_r}), 128'd0);
        check("reset_rd_comb", rd_data, 128'd0);
        check("reset_rd_reg", rd_data_r, 128'd0);
        rd_addr = 4'd7;
        #1;
        check("reset_rd_comb7", rd_data, 128'd0);
        #2;
        rst_n = 1'b1;

        // FIPS-197 key A
        run_expand(KEY_A, 0, '0);
        issue_read(4'd0, KEY_A);
        issue_read(4'd1, KA_R1);
        issue_read(4'd10, KA_R10);
        for (int a = 0; a <= 10; a++) issue_model_read(4'(a));
        drain();

        // Restart from DONE with key B
        run_expand(KEY_B, 0, '0);
        issue_read(4'd10, KB_R10);
        for (int a = 11; a <= 15; a++) issue_read(4'(a), 128'd0);
        drain();

        // Start during expansion is ignored
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        run_expand(k1, 4, k2);
        for (int a = 0; a <= 10; a++) issue_model_read(4'(a));
        drain();

        // Reset in the middle of expansion
        rd_addr = 4'd0;
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_before_abort", 128'(busy), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 128'({busy, busy_r}), 128'd0);
        check("abort_kv", 128'({keys_valid, keys_valid_r}), 128'd0);
        check("abort_rd_comb", rd_data, 128'd0);
        check("abort_rd_reg", rd_data_r, 128'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_abort_kv", 128'({keys_valid, busy}), 128'd0);
        k1 = {$urandom, $urandom, $urandom, $urandom};
        run_expand(k1, 0, '0);
        for (int a = 0; a <= 10; a++) issue_model_read(4'(a));
        drain();

        // Reverse (decrypt-order) sweep against FIPS key A
        run_expand(KEY_A, 0, '0);
        for (int a = 10; a >= 0; a--) issue_model_read(4'(a));
        drain();

        // Random keys with random-order reads, including out-of-range addresses
        for (int k = 0; k < 4; k++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            run_expand(k1, 0, '0);
            for (int j = 0; j < 16; j++) issue_model_read(4'($urandom_range(0, 15)));
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
